sparse_dot_engine: RTL and testbench
====================================

SPARSE_DOT_ENGINE -- requirements
Module: sparse_dot_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, entries in the compressed weight store.
REQ-002 SHALL have parameter INDEX_WIDTH, default 12, activation index width.
REQ-003 SHALL have parameter VALUE_WIDTH, default 16, signed weight width.
REQ-004 SHALL have parameter ACT_WIDTH, default 16, signed activation width.
REQ-005 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width.
REQ-006 SHALL have parameter OUT_WIDTH, default 16, signed result width.
REQ-007 SHALL have one clock and a synchronous active-high reset, with ports clk and rst.
REQ-008 SHALL have these ports, one per line (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a dot product
- base_addr  in  $clog2(DEPTH)  first weight-store entry
- nnz  in  $clog2(DEPTH)+1  count of nonzero entries
- busy  out  1  job in progress or result pending
- ws_en  out  1  weight-store read enable
- ws_addr  out  $clog2(DEPTH)  weight-store address
- ws_idx  in  INDEX_WIDTH  index from store, valid 1 cycle after ws_en
- ws_val  in  VALUE_WIDTH  weight from store, valid 1 cycle after ws_en
- act_en  out  1  activation buffer read enable
- act_addr  out  INDEX_WIDTH  activation address
- act_data  in  ACT_WIDTH  activation, valid 1 cycle after act_en
- result  out  OUT_WIDTH  dot-product result
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result

Function
REQ-009 SHALL implement states IDLE, FETCH, DRAIN and DONE.
REQ-010 In IDLE, start=1 SHALL latch base_addr and nnz, clear the accumulator, and go to FETCH (nnz>0) or DONE (nnz=0).
REQ-011 start SHALL be ignored in every state other than IDLE.
REQ-012 In FETCH, SHALL assert ws_en with ws_addr=(base+k) mod DEPTH for k=0..nnz-1, one per cycle, then enter DRAIN.
REQ-013 One cycle after each ws_en, SHALL assert act_en with act_addr=ws_idx and SHALL register ws_val.
REQ-014 One cycle after each act_en, SHALL add signed(ws_val_reg)*signed(act_data), sign-extended to ACC_WIDTH, to the accumulator (wrap at ACC_WIDTH).
REQ-015 Throughput SHALL be one nonzero per cycle with no bubbles.
REQ-016 DRAIN SHALL last exactly 2 cycles, retiring the in-flight products, then enter DONE.
REQ-017 Outputs SHALL be driven from DONE: result_valid=1, result stable until accepted.
REQ-018 result_valid and result_ready both high SHALL transfer the result and return to IDLE; result_valid SHALL drop the next cycle.
REQ-019 nnz=0 SHALL yield result=0 with result_valid one cycle after start.
REQ-020 Latency from start to result_valid SHALL be nnz+3 cycles for nnz>0.
REQ-021 busy SHALL be 1 in every state other than IDLE.
REQ-022 ws_en and act_en SHALL be 0 whenever no read is issued in that cycle.

Reset
REQ-023 rst=1 SHALL force IDLE and clear the accumulator, the counter, busy, ws_en, act_en and result_valid, and set result to 0.
REQ-024 rst mid-job SHALL abort the job with no result produced; in-flight reads SHALL be discarded.

Configuration
REQ-025 With SPARSE_DOT_SAT_EN defined, result SHALL be the accumulator clamped to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-026 Without SPARSE_DOT_SAT_EN, result SHALL be accumulator[OUT_WIDTH-1:0] (truncation).

Verification
REQ-027 Bench SHALL cover:
- Weights {(2,3),(5,-4),(9,7)}; act[2]=10, act[5]=2, act[9]=1; base=0, nnz=3 -> result=29, result_valid at cycle 6 after start.
- nnz=0 -> result=0, result_valid 1 cycle after start, ws_en never asserted.
- base_addr=1022, nnz=4, DEPTH=1024 -> ws_addr sequence 1022, 1023, 0, 1.
- result_ready held 0 for 5 cycles -> result stable, start ignored, busy=1; then ready=1 -> one transfer, then IDLE.
- Accumulated sum 40000 with OUT_WIDTH=16 -> 32767 with SPARSE_DOT_SAT_EN defined, -25536 without it.
- rst asserted at the 2nd FETCH cycle -> all outputs 0 the next cycle, no result_valid; a new job afterwards is correct.

Source files
------------

// File: rtl/sparse_dot_engine.sv
// sparse_dot_engine: streams compressed (index, weight) pairs, gathers activations and accumulates the dot product.
// Define SPARSE_DOT_SAT_EN to saturate the result instead of truncating it.
module sparse_dot_engine #(
    parameter int DEPTH       = 1024,
    parameter int INDEX_WIDTH = 12,
    parameter int VALUE_WIDTH = 16,
    parameter int ACT_WIDTH   = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(DEPTH)-1:0]   base_addr,
    input  logic [$clog2(DEPTH):0]     nnz,
    output logic                       busy,
    output logic                       ws_en,
    output logic [$clog2(DEPTH)-1:0]   ws_addr,
    input  logic [INDEX_WIDTH-1:0]     ws_idx,
    input  logic [VALUE_WIDTH-1:0]     ws_val,
    output logic                       act_en,
    output logic [INDEX_WIDTH-1:0]     act_addr,
    input  logic [ACT_WIDTH-1:0]       act_data,
    output logic [OUT_WIDTH-1:0]       result,
    output logic                       result_valid,
    input  logic                       result_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = VALUE_WIDTH + ACT_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                        state, state_n;
    logic [AW:0]                   cnt;
    logic [AW-1:0]                 addr;
    logic                          p1, p2;
    logic signed [VALUE_WIDTH-1:0] wv_reg;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [PW-1:0]          prod;
    logic [OUT_WIDTH-1:0]          res_c;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = (nnz == '0) ? DONE : FETCH;
            FETCH: if (cnt == (AW+1)'(1)) state_n = DRAIN;
            DRAIN: if (!p1) state_n = DONE;
            DONE:  if (result_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign prod = wv_reg * $signed(act_data);

    // p1: store data returning (issue activation read); p2: activation returning (accumulate)
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr   <= '0;
            p1     <= 1'b0;
            p2     <= 1'b0;
            wv_reg <= '0;
            acc    <= '0;
        end else begin
            state <= state_n;
            p1    <= (state == FETCH);
            p2    <= p1;
            if (state == IDLE && start) begin
                cnt  <= nnz;
                addr <= base_addr;
                acc  <= '0;
            end else if (state == FETCH) begin
                cnt  <= cnt - 1'b1;
                addr <= (addr == AW'(DEPTH-1)) ? '0 : addr + 1'b1;
            end
            if (p1) wv_reg <= $signed(ws_val);
            if (p2) acc <= acc + ACC_WIDTH'(prod);
        end
    end

`ifdef SPARSE_DOT_SAT_EN
    logic over;
    assign over  = acc[ACC_WIDTH-1] ? ~&acc[ACC_WIDTH-1:OUT_WIDTH-1] : |acc[ACC_WIDTH-1:OUT_WIDTH-1];
    assign res_c = over ? {acc[ACC_WIDTH-1], {(OUT_WIDTH-1){~acc[ACC_WIDTH-1]}}} : acc[OUT_WIDTH-1:0];
`else
    assign res_c = acc[OUT_WIDTH-1:0];
`endif

    assign busy         = (state != IDLE);
    assign ws_en        = (state == FETCH);
    assign ws_addr      = addr;
    assign act_en       = p1;
    assign act_addr     = p1 ? ws_idx : '0;
    assign result_valid = (state == DONE);
    assign result       = (state == DONE) ? res_c : '0;
endmodule

// File: tb/tb_sparse_dot_engine.sv
// tb_sparse_dot_engine: directed scoreboard bench for sparse_dot_engine with behavioural store/activation memories.
module tb_sparse_dot_engine;
    localparam int DEPTH = 1024, IW = 12, VW = 16, AWD = 16, ACW = 40, OW = 16;
    localparam int AB = $clog2(DEPTH);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, result_ready = 1'b1;
    logic [AB-1:0] base_addr = '0;
    logic [AB:0]   nnz = '0;
    logic busy, ws_en, act_en, result_valid;
    logic [AB-1:0] ws_addr;
    logic [IW-1:0] ws_idx, act_addr;
    logic [VW-1:0] ws_val;
    logic [AWD-1:0] act_data;
    logic [OW-1:0] result;

    logic [IW-1:0]         wi [DEPTH];
    logic signed [VW-1:0]  wv [DEPTH];
    logic signed [AWD-1:0] av [2**IW];

    int errors = 0, checks = 0;
    logic signed [OW-1:0] exp_q[$];
    int addr_log[$];

    sparse_dot_engine #(.DEPTH(DEPTH), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .ACT_WIDTH(AWD),
                        .ACC_WIDTH(ACW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .nnz(nnz), .busy(busy),
        .ws_en(ws_en), .ws_addr(ws_addr), .ws_idx(ws_idx), .ws_val(ws_val),
        .act_en(act_en), .act_addr(act_addr), .act_data(act_data),
        .result(result), .result_valid(result_valid), .result_ready(result_ready));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ws_en) begin
            ws_idx <= wi[ws_addr];
            ws_val <= wv[ws_addr];
        end
        if (act_en) act_data <= av[act_addr];
    end

    always @(negedge clk) if (ws_en) addr_log.push_back(int'(ws_addr));

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic signed [OW-1:0] model(input int base, input int n);
        longint s = 0;
        for (int k = 0; k < n; k++) begin
            int a = (base + k) % DEPTH;
            s += longint'(wv[a]) * longint'(av[wi[a]]);
        end
`ifdef SPARSE_DOT_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return OW'(s);
    endfunction

    task automatic run_job(input int base, input int n, input bit stall);
        int lat = 1;
        logic [OW-1:0] held;
        exp_q.push_back(model(base, n));
        addr_log.delete();
        result_ready = !stall;
        start = 1'b1; base_addr = AB'(base); nnz = (AB+1)'(n);
        @(negedge clk);
        start = 1'b0;
        while (!result_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (n == 0) ? 1 : n + 3);
        chk("result", $signed(result), exp_q.pop_front());
        if (stall) begin
            held = result;
            for (int i = 0; i < 5; i++) begin
                start = 1'b1; base_addr = AB'(7); nnz = (AB+1)'(2);
                @(negedge clk);
                chk("stall_hold", result, held);
                chk("stall_valid", result_valid, 1);
                chk("stall_busy", busy, 1);
            end
            start = 1'b0;
            result_ready = 1'b1;
        end
        @(negedge clk);
        chk("valid_drop", result_valid, 0);
        chk("idle_busy", busy, 0);
        chk("ws_count", addr_log.size(), n);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin wi[i] = '0; wv[i] = '0; end
        for (int i = 0; i < 2**IW; i++) av[i] = '0;
        wi[0] = 2; wv[0] = 3; wi[1] = 5; wv[1] = -4; wi[2] = 9; wv[2] = 7;
        av[2] = 10; av[5] = 2; av[9] = 1;
        wi[1022] = 3; wv[1022] = 4; wi[1023] = 4; wv[1023] = -2; av[3] = 5; av[4] = 6;
        wi[100] = 7; wv[100] = 200; wi[101] = 8; wv[101] = 200; av[7] = 100; av[8] = 100;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ws_en", ws_en, 0);
        rst = 1'b0;
        @(negedge clk);

        chk("model_29", model(0, 3), 29);
        run_job(0, 3, 0);
        run_job(0, 0, 0);

        run_job(1022, 4, 0);
        chk("wrap_len", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("wrap_a0", addr_log[0], 1022);
            chk("wrap_a1", addr_log[1], 1023);
            chk("wrap_a2", addr_log[2], 0);
            chk("wrap_a3", addr_log[3], 1);
        end

        run_job(0, 3, 1);

`ifdef SPARSE_DOT_SAT_EN
        chk("model_sat", model(100, 2), 32767);
`else
        chk("model_trunc", model(100, 2), -25536);
`endif
        run_job(100, 2, 0);

        begin
            bit saw = 0;
            start = 1'b1; base_addr = '0; nnz = (AB+1)'(3);
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("fetch2_ws_en", ws_en, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_ws_en", ws_en, 0);
            chk("abort_act_en", act_en, 0);
            chk("abort_valid", result_valid, 0);
            chk("abort_result", result, 0);
            chk("abort_ws_addr", ws_addr, 0);
            chk("abort_act_addr", act_addr, 0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (result_valid || busy) saw = 1;
            end
            chk("abort_no_result", saw, 0);
        end
        run_job(0, 3, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
